// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder.
//   - SPARC op3 codes for the supported load/store instructions
//   - FSM state encoding for the MFA/MFC handshake
//   - access size codes and the decoded-op record used by the top level
package mem_pkg;

    // SPARC op3 codes handled by the responder; anything else is illegal.
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    // Decoded view of a captured op3.
    typedef struct packed {
        logic  legal;
        logic  store;
        size_t size;
        logic  sign;
    } op_info_t;

endpackage

// File: rtl/load_formatter.sv
// load_formatter: combinational extraction of a load result from a
// big-endian 32-bit word.
// Ports:
//   word   - in  32 : word read from the array (byte offset 0 in bits 31:24)
//   offset - in  2  : ADDR[1:0] of the access
//   size   - in     : BYTE / HALF / WORD
//   sign   - in  1  : 1 = sign-extend, 0 = zero-extend
//   result - out 32 : right-justified, extended load value
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (offset)
            2'd0:    sel_byte = word[31:24];
            2'd1:    sel_byte = word[23:16];
            2'd2:    sel_byte = word[15:8];
            default: sel_byte = word[7:0];
        endcase

        // Halfwords are aligned, so only offset[1] picks the half.
        sel_half = offset[1] ? word[15:0] : word[31:16];

        case (size)
            BYTE:    result = {{24{sign & sel_byte[7]}}, sel_byte};
            HALF:    result = {{16{sign & sel_half[15]}}, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory responder answering the MFA/MFC
// four-phase handshake against a 2**ADDR_W byte big-endian array.
// Parameters:
//   WAIT_STATES - idle cycles between request capture and completion (0-15)
//   ADDR_W      - byte-address width
// Ports:
//   Clk     - in  1      : clock, rising edge
//   Clr     - in  1      : synchronous active-high reset
//   MFA     - in  1      : request level, held until MFC is seen
//   OP      - in  6      : SPARC op3
//   ADDR    - in  ADDR_W : byte address
//   DataIn  - in  32     : store data, right-justified for byte/halfword
//   DataOut - out 32     : registered load result
//   MFC     - out 1      : memory function complete
//   MERR    - out 1      : error flag, valid while MFC=1
module mem_responder
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 9
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MFA,
    input  logic [5:0]        OP,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              MERR
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              capture;
    logic              access;

    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;

    op_info_t          info;
    logic [1:0]        offset;
    logic [IDX_W-1:0]  idx;
    logic              misaligned;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic              we;
    logic [31:0]       rword;
    logic [31:0]       load_val;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The access itself happens on the first edge spent in DONE; MFC being
    // still low marks that cycle, so no extra state is needed for it.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        access    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MFA) begin
                    capture   = 1'b1;
                    state_nxt = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MFA) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!MFC) begin
                    access = 1'b1;
                end else if (!MFA) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            cnt <= 4'd0;
        end else if (capture) begin
            cnt <= 4'(WAIT_STATES);
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Request capture: inputs are only looked at here.
    always_ff @(posedge Clk) begin
        if (!Clr && capture) begin
            op_q   <= OP;
            addr_q <= ADDR;
            din_q  <= DataIn;
        end
    end

    // ---------------- decode and alignment ----------------
    always_comb begin
        info.legal = 1'b1;
        info.store = 1'b0;
        info.size  = WORD;
        info.sign  = 1'b0;
        case (op_q)
            OP_LD:   info.size = WORD;
            OP_LDUB: info.size = BYTE;
            OP_LDUH: info.size = HALF;
            OP_LDSB: begin info.size = BYTE; info.sign = 1'b1; end
            OP_LDSH: begin info.size = HALF; info.sign = 1'b1; end
            OP_ST:   begin info.size = WORD; info.store = 1'b1; end
            OP_STB:  begin info.size = BYTE; info.store = 1'b1; end
            OP_STH:  begin info.size = HALF; info.store = 1'b1; end
            default: info.legal = 1'b0;
        endcase
    end

    assign offset = addr_q[1:0];
    assign idx    = addr_q[ADDR_W-1:2];

    always_comb begin
        case (info.size)
            HALF:    misaligned = offset[0];
            WORD:    misaligned = (offset != 2'd0);
            default: misaligned = 1'b0;
        endcase
    end

    assign err = !info.legal || misaligned;

    // Byte enables: be[i] selects byte offset i, i.e. word bits 31-8i.
    // Store data is replicated across lanes so each enabled lane simply
    // picks up its own copy.
    always_comb begin
        be    = 4'b0000;
        wword = din_q;
        case (info.size)
            BYTE: begin
                be[offset] = 1'b1;
                wword      = {4{din_q[7:0]}};
            end
            HALF: begin
                be[{offset[1], 1'b0}] = 1'b1;
                be[{offset[1], 1'b1}] = 1'b1;
                wword                 = {2{din_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = din_q;
            end
        endcase
    end

    // Clr on the completing edge must suppress the commit.
    assign we = access && !Clr && !err && info.store;

    // ---------------- byte-lane array ----------------
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane [DEPTH];

        always_ff @(posedge Clk) begin
            if (we && be[i]) begin
                lane[idx] <= wword[31-8*i -: 8];
            end
        end

        assign rword[31-8*i -: 8] = lane[idx];
    end

    load_formatter u_fmt (
        .word   (rword),
        .offset (offset),
        .size   (info.size),
        .sign   (info.sign),
        .result (load_val)
    );

    // ---------------- response outputs ----------------
    always_ff @(posedge Clk) begin
        if (Clr) begin
            MFC     <= 1'b0;
            MERR    <= 1'b0;
            DataOut <= 32'd0;
        end else if (access) begin
            MFC  <= 1'b1;
            MERR <= err;
            if (!err && !info.store) begin
                DataOut <= load_val;
            end
        end else if (state == S_DONE && !MFA) begin
            MFC  <= 1'b0;
            MERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a transaction-level
// reference model compared against the DUT outputs every cycle.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        MFA;
    logic        MFA0;
    logic [5:0]  OP;
    logic [8:0]  ADDR;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic [31:0] DataOut0;
    logic        MFC;
    logic        MFC0;
    logic        MERR;
    logic        MERR0;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_responder #(.WAIT_STATES(W), .ADDR_W(9)) dut (
        .Clk(Clk), .Clr(Clr), .MFA(MFA), .OP(OP), .ADDR(ADDR),
        .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MERR(MERR)
    );

    mem_responder #(.WAIT_STATES(0), .ADDR_W(9)) dut0 (
        .Clk(Clk), .Clr(Clr), .MFA(MFA0), .OP(OP), .ADDR(ADDR),
        .DataIn(DataIn), .DataOut(DataOut0), .MFC(MFC0), .MERR(MERR0)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mmem [512];
    bit          started = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    int          cyc     = 0;
    int          due     = 0;
    logic [5:0]  m_op;
    logic [8:0]  m_addr;
    logic [31:0] m_din;
    logic [31:0] e_dout = 32'd0;
    logic        e_mfc  = 1'b0;
    logic        e_merr = 1'b0;

    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            OP_LD, OP_ST:             return 4;
            OP_LDUH, OP_LDSH, OP_STH: return 2;
            OP_LDUB, OP_LDSB, OP_STB: return 1;
            default:                  return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == OP_ST) || (op == OP_STB) || (op == OP_STH);
    endfunction

    function automatic bit op_signed(input logic [5:0] op);
        return (op == OP_LDSB) || (op == OP_LDSH);
    endfunction

    // Request captured at edge k completes at edge k+W+1; between those
    // edges a low MFA cancels it.
    initial forever begin
        @(posedge Clk);
        cyc++;
        if (Clr) begin
            started = 1;
            m_busy  = 0;
            m_done  = 0;
            e_mfc   = 1'b0;
            e_merr  = 1'b0;
            e_dout  = 32'd0;
        end else if (m_done) begin
            if (!MFA) begin
                m_done = 0;
                e_mfc  = 1'b0;
                e_merr = 1'b0;
            end
        end else if (m_busy) begin
            if (cyc == due) begin
                int n;
                bit failed;
                n      = op_bytes(m_op);
                failed = (n == 0) || ((int'(m_addr) % n) != 0);
                e_merr = failed;
                e_mfc  = 1'b1;
                m_busy = 0;
                m_done = 1;
                if (!failed) begin
                    if (op_store(m_op)) begin
                        for (int k = 0; k < n; k++)
                            mmem[int'(m_addr) + k] = 8'(m_din >> (8 * (n - 1 - k)));
                    end else begin
                        logic [31:0] v;
                        v = 32'd0;
                        for (int k = 0; k < n; k++)
                            v = (v << 8) | {24'd0, mmem[int'(m_addr) + k]};
                        if (op_signed(m_op) && v[8*n-1])
                            v = v - (32'd1 << (8 * n));
                        e_dout = v;
                    end
                end
            end else if (!MFA) begin
                m_busy = 0;
            end
        end else if (MFA) begin
            m_op   = OP;
            m_addr = ADDR;
            m_din  = DataIn;
            due    = cyc + W + 1;
            m_busy = 1;
        end
    end

    initial forever begin
        @(negedge Clk);
        if (started) begin
            check32("model_dout", DataOut, e_dout);
            check1("model_mfc", MFC, e_mfc);
            check1("model_merr", MERR, e_merr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic [5:0] op, input logic [8:0] addr, input logic [31:0] din,
                          input int hold, output logic [31:0] dout, output logic merr,
                          output int lat);
        @(posedge Clk);
        #2;
        OP = op; ADDR = addr; DataIn = din; MFA = 1'b1;
        @(posedge Clk);
        // Scramble inputs after capture; the responder must ignore them.
        #2;
        OP = 6'b111111; ADDR = ~addr; DataIn = ~din;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk);
            #1;
            lat = i;
            if (MFC) break;
        end
        if (!MFC) begin
            total++;
            bad++;
            $display("FAIL mfc_timeout: got MFC=%b after %0d edges want 1", MFC, lat);
        end
        dout = DataOut;
        merr = MERR;
        repeat (hold) begin
            @(posedge Clk);
            #1;
            check1("hold_mfc", MFC, 1'b1);
        end
        MFA = 1'b0;
        @(posedge Clk);
        #1;
        check1("mfc_fall", MFC, 1'b0);
    endtask

    logic [31:0] d;
    logic        e;
    int          l;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at time %0t want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b1; MFA = 1'b0; MFA0 = 1'b0; OP = 6'd0; ADDR = 9'd0; DataIn = 32'd0;
        repeat (3) @(posedge Clk);
        #2;
        Clr = 1'b0;
        #1;
        check1("reset_mfc", MFC, 1'b0);
        check1("reset_merr", MERR, 1'b0);
        check32("reset_dout", DataOut, 32'd0);

        // Word round trip with latency.
        access(OP_ST, 9'h010, 32'hDEADBEEF, 0, d, e, l);
        check1("st_word_merr", e, 1'b0);
        checkint("st_word_lat", l, 3);
        access(OP_LD, 9'h010, 32'h0, 0, d, e, l);
        check32("ld_word", d, 32'hDEADBEEF);
        check1("ld_word_merr", e, 1'b0);
        checkint("ld_word_lat", l, 3);

        // Byte lanes.
        access(OP_ST, 9'h020, 32'h11223344, 0, d, e, l);
        access(OP_STB, 9'h021, 32'hAAAAAA80, 0, d, e, l);
        access(OP_LDUB, 9'h021, 32'h0, 0, d, e, l);
        check32("ldub", d, 32'h00000080);
        access(OP_LDSB, 9'h021, 32'h0, 0, d, e, l);
        check32("ldsb", d, 32'hFFFFFF80);
        access(OP_LD, 9'h020, 32'h0, 0, d, e, l);
        check32("ld_after_stb", d, 32'h11803344);

        // Halfword.
        access(OP_ST, 9'h030, 32'h55667788, 0, d, e, l);
        access(OP_STH, 9'h032, 32'h12348001, 0, d, e, l);
        access(OP_LDSH, 9'h032, 32'h0, 0, d, e, l);
        check32("ldsh", d, 32'hFFFF8001);
        access(OP_LDUH, 9'h032, 32'h0, 0, d, e, l);
        check32("lduh", d, 32'h00008001);
        access(OP_LD, 9'h030, 32'h0, 0, d, e, l);
        check32("ld_after_sth", d, 32'h55668001);

        // Errors.
        access(OP_LD, 9'h041, 32'h0, 0, d, e, l);
        check1("misaligned_ld_merr", e, 1'b1);
        check32("misaligned_ld_dout", d, 32'h55668001);
        access(OP_ST, 9'h040, 32'hA5A5A5A5, 0, d, e, l);
        access(OP_STH, 9'h043, 32'h0000BEEF, 0, d, e, l);
        check1("misaligned_sth_merr", e, 1'b1);
        access(OP_LD, 9'h040, 32'h0, 0, d, e, l);
        check32("word_after_bad_sth", d, 32'hA5A5A5A5);
        access(6'b000011, 9'h040, 32'h0, 0, d, e, l);
        check1("illegal_op_merr", e, 1'b1);
        check32("illegal_op_dout", d, 32'hA5A5A5A5);

        // MFA held after MFC.
        access(OP_ST, 9'h060, 32'h0BADF00D, 5, d, e, l);
        access(OP_LD, 9'h060, 32'h0, 0, d, e, l);
        check32("ld_after_hold", d, 32'h0BADF00D);

        // Abort in WAIT.
        @(posedge Clk);
        #2;
        OP = OP_ST; ADDR = 9'h010; DataIn = 32'h99999999; MFA = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #2;
        MFA = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check1("abort_mfc", MFC, 1'b0);
        access(OP_LD, 9'h010, 32'h0, 0, d, e, l);
        check32("ld_after_abort", d, 32'hDEADBEEF);

        // Reset in WAIT.
        access(OP_ST, 9'h050, 32'hCAFEF00D, 0, d, e, l);
        @(posedge Clk);
        #2;
        OP = OP_ST; ADDR = 9'h050; DataIn = 32'h12345678; MFA = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Clr = 1'b1;
        @(posedge Clk);
        #2;
        Clr = 1'b0;
        MFA = 1'b0;
        #1;
        check1("clr_wait_mfc", MFC, 1'b0);
        check32("clr_wait_dout", DataOut, 32'd0);
        access(OP_LD, 9'h050, 32'h0, 0, d, e, l);
        check32("ld_after_clr", d, 32'hCAFEF00D);

        // Zero wait states on the second instance.
        @(posedge Clk);
        #2;
        OP = OP_ST; ADDR = 9'h070; DataIn = 32'h76543210; MFA0 = 1'b1;
        @(posedge Clk);
        #1;
        check1("w0_after_capture", MFC0, 1'b0);
        @(posedge Clk);
        #1;
        check1("w0_st_mfc", MFC0, 1'b1);
        check1("w0_st_merr", MERR0, 1'b0);
        MFA0 = 1'b0;
        @(posedge Clk);
        #1;
        check1("w0_mfc_fall", MFC0, 1'b0);
        @(posedge Clk);
        #2;
        OP = OP_LDUH; ADDR = 9'h072; MFA0 = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check1("w0_ld_mfc", MFC0, 1'b1);
        check32("w0_lduh", DataOut0, 32'h00003210);
        MFA0 = 1'b0;
        repeat (2) @(posedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
